// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FE_IDLE = 2'd0,
    FE_WAIT = 2'd1,
    FE_HELD = 2'd2
  } fe_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] PC_INCR           = 32'd4;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry holding register for a word returned while decode is stalled
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, instruction memory request, skid and FE/DE register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        STALL_FE,
  input  logic        STALL_DE,
  input  logic        FLUSH,
  input  logic [31:0] PC_TARGET,
  output logic        IMEM_EN,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] PC_FE,
  output logic [31:0] PC_DE,
  output logic [31:0] INSTR_DE,
  output logic        VALID_DE
);

  fe_state_t   fe_state, fe_state_nxt;
  logic [31:0] infl_pc;
  logic        stall, issue;
  logic        fd_load_mem, fd_load_skid, fd_bubble;
  logic        skid_load, skid_clear, skid_valid;
  logic [31:0] skid_pc, skid_instr;

  assign stall     = STALL_FE | STALL_DE;
  assign issue     = ~stall & ~FLUSH;
  // Gated by rst so the strobe drops the moment reset asserts, not at the next edge.
  assign IMEM_EN   = issue & rst;
  assign IMEM_ADDR = PC_FE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fe_state <= FE_IDLE;
    else      fe_state <= fe_state_nxt;
  end

  always_comb begin
    fe_state_nxt = fe_state;
    if (FLUSH) begin
      fe_state_nxt = FE_IDLE;
    end else begin
      case (fe_state)
        FE_IDLE: fe_state_nxt = issue ? FE_WAIT : FE_IDLE;
        FE_WAIT: fe_state_nxt = STALL_DE ? FE_HELD : (issue ? FE_WAIT : FE_IDLE);
        FE_HELD: fe_state_nxt = STALL_DE ? FE_HELD : (issue ? FE_WAIT : FE_IDLE);
        default: fe_state_nxt = FE_IDLE;
      endcase
    end
  end

  always_comb begin
    fd_load_mem  = 1'b0;
    fd_load_skid = 1'b0;
    fd_bubble    = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if (FLUSH) begin
      fd_bubble  = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (fe_state)
        FE_IDLE: fd_bubble = ~STALL_DE;
        FE_WAIT: begin
          fd_load_mem = ~STALL_DE;
          skid_load   = STALL_DE;
        end
        FE_HELD: begin
          fd_load_skid = ~STALL_DE & skid_valid;
          skid_clear   = ~STALL_DE;
        end
        default: fd_bubble = ~STALL_DE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_FE   <= RESET_PC;
      infl_pc <= 32'h0;
    end else if (FLUSH) begin
      PC_FE <= PC_TARGET;
    end else if (issue) begin
      PC_FE   <= PC_FE + PC_INCR;
      infl_pc <= PC_FE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      VALID_DE <= 1'b0;
      INSTR_DE <= NOP_INSTR;
      PC_DE    <= 32'h0;
    end else if (fd_bubble) begin
      VALID_DE <= 1'b0;
      INSTR_DE <= NOP_INSTR;
    end else if (fd_load_mem) begin
      VALID_DE <= 1'b1;
      INSTR_DE <= IMEM_RDATA;
      PC_DE    <= infl_pc;
    end else if (fd_load_skid) begin
      VALID_DE <= 1'b1;
      INSTR_DE <= skid_instr;
      PC_DE    <= skid_pc;
    end
  end

  fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (infl_pc),
    .load_instr (IMEM_RDATA),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

endmodule
